// File: rtl/hazard3_pmp_seq_if.sv
// hazard3_pmp_seq_if
// Bundles the CSR config port, the access-query request channel and the
// result channel of the sequential PMP checker.
//   cfg_addr/cfg_wen/cfg_wdata -> CSR write port, cfg_rdata <- CSR read data
//   req_valid/req_addr/req_m_mode/req_type -> query, req_ready <- accepted
//   resp_valid/resp_kill/resp_match/resp_region <- result, resp_ready -> consumed
// The master modport is the requester/CSR side, the slave modport is the checker.
interface hazard3_pmp_seq_if #(
    parameter int W_ADDR = 32
);
    logic [11:0]       cfg_addr;
    logic              cfg_wen;
    logic [31:0]       cfg_wdata;
    logic [31:0]       cfg_rdata;

    logic              req_valid;
    logic              req_ready;
    logic [W_ADDR-1:0] req_addr;
    logic              req_m_mode;
    logic [1:0]        req_type;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_kill;
    logic              resp_match;
    logic [5:0]        resp_region;

    modport master (
        output cfg_addr, cfg_wen, cfg_wdata,
        input  cfg_rdata,
        output req_valid, req_addr, req_m_mode, req_type,
        input  req_ready,
        input  resp_valid, resp_kill, resp_match, resp_region,
        output resp_ready
    );

    modport slave (
        input  cfg_addr, cfg_wen, cfg_wdata,
        output cfg_rdata,
        input  req_valid, req_addr, req_m_mode, req_type,
        output req_ready,
        output resp_valid, resp_kill, resp_match, resp_region,
        input  resp_ready
    );
endinterface

// File: rtl/hazard3_pmp_seq.sv
// hazard3_pmp_seq
// Sequential physical memory protection checker. Holds the pmpcfg/pmpaddr
// CSR state and answers one access query at a time, scanning LANES regions
// per cycle (IDLE -> SCAN -> RESP).
// Ports:
//   clk  - single clock
//   rst  - synchronous active-high reset (FSM and CSR state)
//   bus  - hazard3_pmp_seq_if.slave: CSR port, query request, query result
module hazard3_pmp_seq #(
    parameter int PMP_REGIONS = 16,
    parameter int LANES       = 4,
    parameter int W_ADDR      = 32
) (
    input  logic               clk,
    input  logic               rst,
    hazard3_pmp_seq_if.slave   bus
);
    localparam int W_PA    = W_ADDR - 2;
    localparam int N_BATCH = PMP_REGIONS / LANES;
    localparam int W_BATCH = (N_BATCH > 1) ? $clog2(N_BATCH) : 1;

    localparam logic [1:0] A_OFF   = 2'b00;
    localparam logic [1:0] A_TOR   = 2'b01;
    localparam logic [1:0] A_NA4   = 2'b10;
    localparam logic [1:0] A_NAPOT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

    state_t                 state, state_next;
    logic [W_BATCH-1:0]     batch, batch_next;

    logic [PMP_REGIONS-1:0] cfg_l, cfg_x, cfg_w, cfg_r;
    logic [1:0]             cfg_a   [PMP_REGIONS];
    logic [W_PA-1:0]        pmpaddr [PMP_REGIONS];
    logic [W_PA-1:0]        tor_lo  [PMP_REGIONS];
    logic [PMP_REGIONS-1:0] addr_locked;

    logic [W_ADDR-1:0]      q_addr;
    logic                   q_m_mode;
    logic [1:0]             q_type;

    logic                   kill_q, match_q, kill_next, match_next;
    logic [5:0]             region_q, region_next;

    logic                   is_cfg, is_addr, restart;
    logic [5:0]             addr_idx;

    logic [1:0]             lane_a  [LANES];
    logic [W_PA-1:0]        lane_hi [LANES];
    logic [W_PA-1:0]        lane_lo [LANES];
    logic [LANES-1:0]       lane_l, lane_r, lane_w, lane_x, lane_hit;

    logic                   any_hit, hit_kill;
    logic [5:0]             hit_region;

    // CSR address decode; writes anywhere in the PMP window restart a scan,
    // whether or not a lock ends up blocking them.
    assign is_cfg   = (bus.cfg_addr[11:4] == 8'h3a);
    assign is_addr  = (bus.cfg_addr >= 12'h3b0) && (bus.cfg_addr <= 12'h3ef);
    assign addr_idx = 6'(bus.cfg_addr - 12'h3b0);
    assign restart  = bus.cfg_wen && (is_cfg || is_addr);

    // pmpaddr[i] is frozen by its own lock, and also by a locked TOR region
    // i+1 that uses it as its lower bound. TOR region 0 has a lower bound of 0.
    for (genvar g = 0; g < PMP_REGIONS; g++) begin : g_region
        if (g + 1 < PMP_REGIONS) begin : g_mid
            assign addr_locked[g] = cfg_l[g] | (cfg_l[g+1] & (cfg_a[g+1] == A_TOR));
        end else begin : g_last
            assign addr_locked[g] = cfg_l[g];
        end
        if (g == 0) begin : g_first
            assign tor_lo[g] = '0;
        end else begin : g_rest
            assign tor_lo[g] = pmpaddr[g-1];
        end
    end

    // CSR read mux; unimplemented regions read as zero, bits 6:5 always zero.
    always_comb begin
        bus.cfg_rdata = '0;
        for (int i = 0; i < PMP_REGIONS; i++) begin
            if (is_cfg && bus.cfg_addr[3:0] == 4'(i / 4)) begin
                bus.cfg_rdata[8*(i%4) +: 8] = {cfg_l[i], 2'b00, cfg_a[i], cfg_x[i], cfg_w[i], cfg_r[i]};
            end
            if (is_addr && addr_idx == 6'(i)) begin
                bus.cfg_rdata = 32'(pmpaddr[i]);
            end
        end
    end

    // CSR state; locks are sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_l <= '0;
            cfg_x <= '0;
            cfg_w <= '0;
            cfg_r <= '0;
            for (int i = 0; i < PMP_REGIONS; i++) begin
                cfg_a[i]   <= A_OFF;
                pmpaddr[i] <= '0;
            end
        end else if (bus.cfg_wen) begin
            for (int i = 0; i < PMP_REGIONS; i++) begin
                if (is_cfg && bus.cfg_addr[3:0] == 4'(i / 4) && !cfg_l[i]) begin
                    cfg_l[i] <= bus.cfg_wdata[8*(i%4) + 7];
                    cfg_a[i] <= bus.cfg_wdata[8*(i%4) + 3 +: 2];
                    cfg_x[i] <= bus.cfg_wdata[8*(i%4) + 2];
                    cfg_w[i] <= bus.cfg_wdata[8*(i%4) + 1];
                    cfg_r[i] <= bus.cfg_wdata[8*(i%4)];
                end
                if (is_addr && addr_idx == 6'(i) && !addr_locked[i]) begin
                    pmpaddr[i] <= W_PA'(bus.cfg_wdata);
                end
            end
        end
    end

    // Steer the current batch's region operands onto the LANES comparators.
    always_comb begin
        lane_l = '0;
        lane_r = '0;
        lane_w = '0;
        lane_x = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_a[l]  = A_OFF;
            lane_hi[l] = '0;
            lane_lo[l] = '0;
        end
        for (int b = 0; b < N_BATCH; b++) begin
            if (batch == W_BATCH'(b)) begin
                for (int l = 0; l < LANES; l++) begin
                    lane_a[l]  = cfg_a[b*LANES + l];
                    lane_hi[l] = pmpaddr[b*LANES + l];
                    lane_lo[l] = tor_lo[b*LANES + l];
                    lane_l[l]  = cfg_l[b*LANES + l];
                    lane_r[l]  = cfg_r[b*LANES + l];
                    lane_w[l]  = cfg_w[b*LANES + l];
                    lane_x[l]  = cfg_x[b*LANES + l];
                end
            end
        end
    end

    // Per-lane address match. NAPOT masks off the trailing ones of pmpaddr
    // plus the lowest zero: hi ^ (hi + 1) marks exactly those bits.
    always_comb begin
        lane_hit = '0;
        for (int l = 0; l < LANES; l++) begin
            case (lane_a[l])
                A_NA4:   lane_hit[l] = (q_addr[W_ADDR-1:2] == lane_hi[l]);
                A_NAPOT: lane_hit[l] = ((q_addr[W_ADDR-1:2] ^ lane_hi[l])
                                        & ~(lane_hi[l] ^ (lane_hi[l] + W_PA'(1)))) == '0;
                A_TOR:   lane_hit[l] = ({lane_lo[l], 2'b00} <= q_addr) && (q_addr < {lane_hi[l], 2'b00});
                default: lane_hit[l] = 1'b0;
            endcase
        end
    end

    // Lowest hitting lane wins; scanning downward lets the lowest overwrite.
    always_comb begin
        any_hit    = 1'b0;
        hit_kill   = 1'b0;
        hit_region = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_hit[l]) begin
                any_hit    = 1'b1;
                hit_region = 6'(int'(batch) * LANES + l);
                case (q_type)
                    2'd1:    hit_kill = (!q_m_mode || lane_l[l]) && !lane_w[l];
                    2'd2:    hit_kill = (!q_m_mode || lane_l[l]) && !lane_x[l];
                    default: hit_kill = (!q_m_mode || lane_l[l]) && !lane_r[l];
                endcase
            end
        end
    end

    // FSM next-state and result capture. A PMP CSR write during SCAN beats
    // any hit found in the same cycle, since that hit used stale config.
    always_comb begin
        state_next  = state;
        batch_next  = batch;
        kill_next   = kill_q;
        match_next  = match_q;
        region_next = region_q;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_next = S_SCAN;
                    batch_next = '0;
                end
            end
            S_SCAN: begin
                if (restart) begin
                    batch_next = '0;
                end else if (any_hit) begin
                    state_next  = S_RESP;
                    kill_next   = hit_kill;
                    match_next  = 1'b1;
                    region_next = hit_region;
                end else if (batch == W_BATCH'(N_BATCH - 1)) begin
                    state_next  = S_RESP;
                    kill_next   = !q_m_mode;
                    match_next  = 1'b0;
                    region_next = '0;
                end else begin
                    batch_next = batch + W_BATCH'(1);
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, batch, latched query and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            batch    <= '0;
            q_addr   <= '0;
            q_m_mode <= 1'b0;
            q_type   <= 2'd0;
            kill_q   <= 1'b0;
            match_q  <= 1'b0;
            region_q <= '0;
        end else begin
            state    <= state_next;
            batch    <= batch_next;
            kill_q   <= kill_next;
            match_q  <= match_next;
            region_q <= region_next;
            if (state == S_IDLE && bus.req_valid) begin
                q_addr   <= bus.req_addr;
                q_m_mode <= bus.req_m_mode;
                q_type   <= bus.req_type;
            end
        end
    end

    assign bus.req_ready   = (state == S_IDLE) && !rst;
    assign bus.resp_valid  = (state == S_RESP);
    assign bus.resp_kill   = kill_q;
    assign bus.resp_match  = match_q;
    assign bus.resp_region = region_q;
endmodule

// File: tb/tb_hazard3_pmp_seq.sv
// tb_hazard3_pmp_seq
// Directed bench for hazard3_pmp_seq: one instance with 16 regions / 4 lanes
// and one with 16 regions / 1 lane (used for the scan-restart scenario).
module tb_hazard3_pmp_seq;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    hazard3_pmp_seq_if #(.W_ADDR(32)) bus4 ();
    hazard3_pmp_seq_if #(.W_ADDR(32)) bus1 ();

    hazard3_pmp_seq #(.PMP_REGIONS(16), .LANES(4), .W_ADDR(32)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    hazard3_pmp_seq #(.PMP_REGIONS(16), .LANES(1), .W_ADDR(32)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic csr_write4(input logic [11:0] a, input logic [31:0] d);
        bus4.cfg_addr  = a;
        bus4.cfg_wdata = d;
        bus4.cfg_wen   = 1'b1;
        tick();
        bus4.cfg_wen   = 1'b0;
    endtask

    task automatic csr_read4(input logic [11:0] a, output logic [31:0] d);
        bus4.cfg_addr = a;
        #1;
        d = bus4.cfg_rdata;
    endtask

    task automatic csr_write1(input logic [11:0] a, input logic [31:0] d);
        bus1.cfg_addr  = a;
        bus1.cfg_wdata = d;
        bus1.cfg_wen   = 1'b1;
        tick();
        bus1.cfg_wen   = 1'b0;
    endtask

    // Issue one query on the 4-lane instance; lat counts cycles from the
    // accepting edge to the first cycle with resp_valid high.
    task automatic query4(input logic [31:0] addr, input logic m, input logic [1:0] typ,
                          output int lat, output logic kill, output logic match,
                          output logic [5:0] region);
        int guard;
        bus4.req_addr   = addr;
        bus4.req_m_mode = m;
        bus4.req_type   = typ;
        bus4.req_valid  = 1'b1;
        guard = 0;
        while (bus4.req_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        bus4.req_valid = 1'b0;
        lat = 1;
        while (bus4.resp_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        kill   = bus4.resp_kill;
        match  = bus4.resp_match;
        region = bus4.resp_region;
        bus4.resp_ready = 1'b1;
        tick();
        bus4.resp_ready = 1'b0;
    endtask

    // Same for the 1-lane instance, optionally writing a PMP CSR during the
    // 4th SCAN cycle.
    task automatic query1(input logic [31:0] addr, input logic m, input logic [1:0] typ,
                          input logic inject, input logic [11:0] wa, input logic [31:0] wd,
                          output int lat, output logic kill, output logic match,
                          output logic [5:0] region);
        int guard;
        bus1.req_addr   = addr;
        bus1.req_m_mode = m;
        bus1.req_type   = typ;
        bus1.req_valid  = 1'b1;
        guard = 0;
        while (bus1.req_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        bus1.req_valid = 1'b0;
        lat = 1;
        while (bus1.resp_valid !== 1'b1 && lat < 100) begin
            if (inject && lat == 4) begin
                bus1.cfg_addr  = wa;
                bus1.cfg_wdata = wd;
                bus1.cfg_wen   = 1'b1;
            end
            tick();
            bus1.cfg_wen = 1'b0;
            lat++;
        end
        kill   = bus1.resp_kill;
        match  = bus1.resp_match;
        region = bus1.resp_region;
        bus1.resp_ready = 1'b1;
        tick();
        bus1.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus4.req_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ready_during: got %b want 0", bus4.req_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus4.req_ready, bus4.resp_valid, bus4.resp_kill, bus4.resp_match, bus4.resp_region} !== 10'b10_0000_0000) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got ready=%b valid=%b kill=%b match=%b region=%0d want 1 0 0 0 0",
                     bus4.req_ready, bus4.resp_valid, bus4.resp_kill, bus4.resp_match, bus4.resp_region);
        end
        n_cmp++;
        if (bus1.req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_ready_lane1: got %b want 1", bus1.req_ready);
        end
        csr_read4(12'h3a0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_pmpcfg0: got %h want 00000000", d);
        end
    endtask

    task automatic test_csr();
        logic [31:0] d;
        do_reset();
        csr_write4(12'h3a0, 32'h0000_00ff);
        csr_read4(12'h3a0, d);
        n_cmp++;
        if (d !== 32'h0000_009f) begin
            n_fail++;
            $display("[TB] FAIL csr_cfg_reserved_bits: got %h want 0000009f", d);
        end
        csr_write4(12'h3b5, 32'hffff_ffff);
        csr_read4(12'h3b5, d);
        n_cmp++;
        if (d !== 32'h3fff_ffff) begin
            n_fail++;
            $display("[TB] FAIL csr_pmpaddr_width: got %h want 3fffffff", d);
        end
        csr_write4(12'h3c0, 32'h1234_5678);
        csr_read4(12'h3c0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL csr_unimpl_addr: got %h want 00000000", d);
        end
        csr_write4(12'h3a4, 32'hffff_ffff);
        csr_read4(12'h3a4, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL csr_unimpl_cfg: got %h want 00000000", d);
        end
    endtask

    task automatic test_napot();
        int lat;
        logic kill, match;
        logic [5:0] region;
        do_reset();
        csr_write4(12'h3b0, 32'h0000_03ff);
        csr_write4(12'h3a0, 32'h0000_0019);
        query4(32'h1ffc, 1'b0, 2'd0, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd2, 1'b0, 1'b1, 6'd0}) begin
            n_fail++;
            $display("[TB] FAIL napot_read_in: got lat=%0d kill=%b match=%b region=%0d want lat=2 kill=0 match=1 region=0", lat, kill, match, region);
        end
        query4(32'h1ffc, 1'b0, 2'd1, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd2, 1'b1, 1'b1, 6'd0}) begin
            n_fail++;
            $display("[TB] FAIL napot_write_in: got lat=%0d kill=%b match=%b region=%0d want lat=2 kill=1 match=1 region=0", lat, kill, match, region);
        end
        query4(32'h2000, 1'b0, 2'd0, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd5, 1'b1, 1'b0, 6'd0}) begin
            n_fail++;
            $display("[TB] FAIL napot_read_out: got lat=%0d kill=%b match=%b region=%0d want lat=5 kill=1 match=0 region=0", lat, kill, match, region);
        end
        query4(32'h2000, 1'b1, 2'd3, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd5, 1'b0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("[TB] FAIL napot_mmode_nomatch: got lat=%0d kill=%b match=%b region=%0d want lat=5 kill=0 match=0 region=0", lat, kill, match, region);
        end
    endtask

    task automatic test_tor();
        int lat;
        logic kill, match;
        logic [5:0] region;
        do_reset();
        csr_write4(12'h3b4, 32'h0000_0400);
        csr_write4(12'h3b5, 32'h0000_0800);
        csr_write4(12'h3a1, 32'h0000_0c00);
        query4(32'h1000, 1'b0, 2'd2, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd3, 1'b0, 1'b1, 6'd5}) begin
            n_fail++;
            $display("[TB] FAIL tor_exec_low_edge: got lat=%0d kill=%b match=%b region=%0d want lat=3 kill=0 match=1 region=5", lat, kill, match, region);
        end
        query4(32'h0ffc, 1'b0, 2'd2, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd5, 1'b1, 1'b0, 6'd0}) begin
            n_fail++;
            $display("[TB] FAIL tor_exec_below: got lat=%0d kill=%b match=%b region=%0d want lat=5 kill=1 match=0 region=0", lat, kill, match, region);
        end
        query4(32'h2000, 1'b0, 2'd2, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd5, 1'b1, 1'b0, 6'd0}) begin
            n_fail++;
            $display("[TB] FAIL tor_exec_top_excl: got lat=%0d kill=%b match=%b region=%0d want lat=5 kill=1 match=0 region=0", lat, kill, match, region);
        end
        query4(32'h1ffc, 1'b0, 2'd0, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd3, 1'b1, 1'b1, 6'd5}) begin
            n_fail++;
            $display("[TB] FAIL tor_read_noperm: got lat=%0d kill=%b match=%b region=%0d want lat=3 kill=1 match=1 region=5", lat, kill, match, region);
        end
    endtask

    task automatic test_priority();
        int lat;
        logic kill, match;
        logic [5:0] region;
        do_reset();
        csr_write4(12'h3b1, 32'h0000_01ff);
        csr_write4(12'h3b2, 32'h0000_0040);
        csr_write4(12'h3a0, 32'h0010_1900);
        query4(32'h0100, 1'b0, 2'd0, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd2, 1'b0, 1'b1, 6'd1}) begin
            n_fail++;
            $display("[TB] FAIL prio_lowest_wins: got lat=%0d kill=%b match=%b region=%0d want lat=2 kill=0 match=1 region=1", lat, kill, match, region);
        end
        query4(32'h1000, 1'b0, 2'd0, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd5, 1'b1, 1'b0, 6'd0}) begin
            n_fail++;
            $display("[TB] FAIL prio_outside: got lat=%0d kill=%b match=%b region=%0d want lat=5 kill=1 match=0 region=0", lat, kill, match, region);
        end
    endtask

    task automatic test_lock();
        int lat;
        logic kill, match;
        logic [5:0] region;
        logic [31:0] d;
        do_reset();
        csr_write4(12'h3b2, 32'h0000_0040);
        csr_write4(12'h3b3, 32'h0000_0080);
        csr_write4(12'h3a0, 32'h8800_0000);
        query4(32'h0180, 1'b1, 2'd0, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd2, 1'b1, 1'b1, 6'd3}) begin
            n_fail++;
            $display("[TB] FAIL lock_mmode_read: got lat=%0d kill=%b match=%b region=%0d want lat=2 kill=1 match=1 region=3", lat, kill, match, region);
        end
        query4(32'h0200, 1'b1, 2'd0, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd5, 1'b0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("[TB] FAIL lock_mmode_outside: got lat=%0d kill=%b match=%b region=%0d want lat=5 kill=0 match=0 region=0", lat, kill, match, region);
        end
        csr_write4(12'h3a0, 32'h0000_0000);
        csr_read4(12'h3a0, d);
        n_cmp++;
        if (d !== 32'h8800_0000) begin
            n_fail++;
            $display("[TB] FAIL lock_cfg_byte: got %h want 88000000", d);
        end
        csr_write4(12'h3b3, 32'h0000_0123);
        csr_read4(12'h3b3, d);
        n_cmp++;
        if (d !== 32'h0000_0080) begin
            n_fail++;
            $display("[TB] FAIL lock_pmpaddr3: got %h want 00000080", d);
        end
        csr_write4(12'h3b2, 32'h0000_0123);
        csr_read4(12'h3b2, d);
        n_cmp++;
        if (d !== 32'h0000_0040) begin
            n_fail++;
            $display("[TB] FAIL lock_pmpaddr2_tor: got %h want 00000040", d);
        end
        csr_write4(12'h3b1, 32'h0000_0055);
        csr_read4(12'h3b1, d);
        n_cmp++;
        if (d !== 32'h0000_0055) begin
            n_fail++;
            $display("[TB] FAIL lock_pmpaddr1_free: got %h want 00000055", d);
        end
    endtask

    task automatic test_restart();
        int lat;
        logic kill, match;
        logic [5:0] region;
        logic [31:0] d;
        do_reset();
        csr_write1(12'h3ba, 32'h0000_0100);
        csr_write1(12'h3a2, 32'h0010_0000);
        query1(32'h0400, 1'b0, 2'd0, 1'b0, 12'h000, 32'h0, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd12, 1'b1, 1'b1, 6'd10}) begin
            n_fail++;
            $display("[TB] FAIL restart_baseline: got lat=%0d kill=%b match=%b region=%0d want lat=12 kill=1 match=1 region=10", lat, kill, match, region);
        end
        query1(32'h0400, 1'b0, 2'd0, 1'b1, 12'h3b0, 32'h0000_0077, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd16, 1'b1, 1'b1, 6'd10}) begin
            n_fail++;
            $display("[TB] FAIL restart_addr_write: got lat=%0d kill=%b match=%b region=%0d want lat=16 kill=1 match=1 region=10", lat, kill, match, region);
        end
        bus1.cfg_addr = 12'h3b0;
        #1;
        d = bus1.cfg_rdata;
        n_cmp++;
        if (d !== 32'h0000_0077) begin
            n_fail++;
            $display("[TB] FAIL restart_readback: got %h want 00000077", d);
        end
        query1(32'h0400, 1'b0, 2'd0, 1'b1, 12'h3a2, 32'h0011_0000, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd16, 1'b0, 1'b1, 6'd10}) begin
            n_fail++;
            $display("[TB] FAIL restart_new_perm: got lat=%0d kill=%b match=%b region=%0d want lat=16 kill=0 match=1 region=10", lat, kill, match, region);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic kill, match;
        logic [5:0] region;
        logic [31:0] d;
        do_reset();
        csr_write4(12'h3b0, 32'h0000_03ff);
        csr_write4(12'h3a0, 32'h0000_0019);
        bus4.req_addr   = 32'h1ffc;
        bus4.req_m_mode = 1'b0;
        bus4.req_type   = 2'd0;
        bus4.req_valid  = 1'b1;
        tick();
        bus4.req_valid = 1'b0;
        lat = 1;
        while (bus4.resp_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        // Hold the result; a config write while in RESP must not disturb it.
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({bus4.resp_valid, bus4.req_ready, bus4.resp_kill, bus4.resp_match, bus4.resp_region} !== 10'b10_0100_0000) begin
                n_fail++;
                $display("[TB] FAIL hold_cycle%0d: got valid=%b ready=%b kill=%b match=%b region=%0d want 1 0 0 1 0",
                         i, bus4.resp_valid, bus4.req_ready, bus4.resp_kill, bus4.resp_match, bus4.resp_region);
            end
            if (i == 4) begin
                bus4.cfg_addr  = 12'h3a0;
                bus4.cfg_wdata = 32'h0;
                bus4.cfg_wen   = 1'b1;
            end
            tick();
            bus4.cfg_wen = 1'b0;
        end
        bus4.resp_ready = 1'b1;
        tick();
        bus4.resp_ready = 1'b0;
        n_cmp++;
        if ({bus4.req_ready, bus4.resp_valid} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL b2b_idle: got ready=%b valid=%b want 1 0", bus4.req_ready, bus4.resp_valid);
        end
        csr_read4(12'h3a0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL b2b_cfg_written: got %h want 00000000", d);
        end
        query4(32'h1ffc, 1'b0, 2'd1, lat, kill, match, region);
        n_cmp++;
        if ({lat, kill, match, region} !== {32'd5, 1'b1, 1'b0, 6'd0}) begin
            n_fail++;
            $display("[TB] FAIL b2b_next_query: got lat=%0d kill=%b match=%b region=%0d want lat=5 kill=1 match=0 region=0", lat, kill, match, region);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] d;
        int seen;
        do_reset();
        csr_write4(12'h3a0, 32'h0000_0019);
        bus4.req_addr   = 32'h2000;
        bus4.req_m_mode = 1'b0;
        bus4.req_type   = 2'd0;
        bus4.req_valid  = 1'b1;
        tick();
        bus4.req_valid = 1'b0;
        n_cmp++;
        if (bus4.req_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midscan_busy: got ready=%b want 0", bus4.req_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({bus4.req_ready, bus4.resp_valid} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL midscan_after_reset: got ready=%b valid=%b want 1 0", bus4.req_ready, bus4.resp_valid);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus4.resp_valid === 1'b1) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("[TB] FAIL midscan_dropped: got %0d resp_valid cycles want 0", seen);
        end
        csr_read4(12'h3a0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL midscan_csr_reset: got %h want 00000000", d);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus4.cfg_addr = '0; bus4.cfg_wen = 1'b0; bus4.cfg_wdata = '0;
        bus4.req_valid = 1'b0; bus4.req_addr = '0; bus4.req_m_mode = 1'b0;
        bus4.req_type = 2'd0; bus4.resp_ready = 1'b0;
        bus1.cfg_addr = '0; bus1.cfg_wen = 1'b0; bus1.cfg_wdata = '0;
        bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.req_m_mode = 1'b0;
        bus1.req_type = 2'd0; bus1.resp_ready = 1'b0;

        test_reset();
        test_csr();
        test_napot();
        test_tor();
        test_priority();
        test_lock();
        test_restart();
        test_back_to_back();
        test_reset_mid_scan();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
